// File: rtl/rv_ctrl_pkg.sv
// Shared definitions for the multi-cycle RV64 subset controller.
//   - state encoding (FETCH=0 .. HALT=9)
//   - major opcodes and funct3 codes of the supported instructions
//   - ALU control codes and alu_src_b select codes
package rv_ctrl_pkg;

    typedef enum logic [3:0] {
        ST_FETCH    = 4'd0,
        ST_DECODE   = 4'd1,
        ST_MEM_ADDR = 4'd2,
        ST_MEM_RD   = 4'd3,
        ST_MEM_WB   = 4'd4,
        ST_MEM_WR   = 4'd5,
        ST_EXEC     = 4'd6,
        ST_ALU_WB   = 4'd7,
        ST_BRANCH   = 4'd8,
        ST_HALT     = 4'd9
    } state_e;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_AND = 3'b111;
    localparam logic [2:0] F3_OR  = 3'b110;
    localparam logic [2:0] F3_BEQ = 3'b000;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_FOUR = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;

endpackage

// File: rtl/alu_ctrl_dec.sv
// Combinational instruction-field decoder.
// Maps opcode/funct3/funct7 to the ALU operation used in EXEC and flags
// whether the encoding belongs to the supported subset (used in DECODE).
// Ports:
//   opcode   in  7   instr[6:0]
//   funct3   in  3   instr[14:12]
//   funct7   in  7   instr[31:25]
//   alu_ctrl out 4   ALU operation for the register/immediate ALU ops
//   legal    out 1   encoding is supported
module alu_ctrl_dec
    import rv_ctrl_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    output logic [3:0] alu_ctrl,
    output logic       legal
);

    always_comb begin
        alu_ctrl = ALU_ADD;
        legal    = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                case ({funct7, funct3})
                    {F7_BASE, F3_ADD}: legal = 1'b1;
                    {F7_ALT,  F3_ADD}: begin
                        alu_ctrl = ALU_SUB;
                        legal    = 1'b1;
                    end
                    {F7_BASE, F3_AND}: begin
                        alu_ctrl = ALU_AND;
                        legal    = 1'b1;
                    end
                    {F7_BASE, F3_OR}: begin
                        alu_ctrl = ALU_OR;
                        legal    = 1'b1;
                    end
                    default: ;
                endcase
            end
            OP_IMM:    legal = (funct3 == F3_ADD);
            OP_BRANCH: legal = (funct3 == F3_BEQ);
            OP_LOAD,
            OP_STORE:  legal = 1'b1;
            default:   ;
        endcase
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM for the RV64 subset core (add/sub/and/or, addi, ld, sd, beq).
// Drives the shared datapath selects/enables one state at a time and runs a
// request/ready handshake on the single memory port with a timeout.
// Optional build macro: MC_PERF_CNT_EN adds cycle_cnt / instret_cnt outputs.
// Ports:
//   clk, rst_n            clock / asynchronous active-low reset
//   instr[31:0]           instruction register contents
//   zero                  ALU zero flag
//   mem_ready             memory accepts/completes the current request
//   mem_req, mem_we, iord memory request, store select, address select
//   ir_write, pc_write, pc_src, alu_src_a, alu_src_b[1:0], alu_ctrl[3:0]
//   reg_write, mem_to_reg datapath enables and selects
//   illegal, bus_err      sticky halt causes
//   cycle_cnt, instret_cnt performance counters (MC_PERF_CNT_EN only)
//   state[3:0]            current state
//
// state     | meaning
// ----------+-------------------------------------------------
// FETCH     | read instruction at PC, PC+4 -> PC on ready
// DECODE    | branch target into ALUOut, dispatch on opcode
// MEM_ADDR  | rs1 + imm for ld/sd
// MEM_RD    | load request at ALUOut
// MEM_WB    | MDR -> rd
// MEM_WR    | store request at ALUOut
// EXEC      | R-type / addi ALU operation
// ALU_WB    | ALUOut -> rd
// BRANCH    | rs1 - rs2, take target when zero
// HALT      | stopped until reset
module multicycle_ctrl
    import rv_ctrl_pkg::*;
#(
    parameter int MAX_WAIT = 16
`ifdef MC_PERF_CNT_EN
    ,
    parameter int CNT_W    = 32
`endif
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      instr,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_we,
    output logic             iord,
    output logic             ir_write,
    output logic             pc_write,
    output logic             pc_src,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [3:0]       alu_ctrl,
    output logic             reg_write,
    output logic             mem_to_reg,
    output logic             illegal,
    output logic             bus_err,
`ifdef MC_PERF_CNT_EN
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instret_cnt,
`endif
    output logic [3:0]       state
);

    localparam int WAIT_W = $clog2(MAX_WAIT + 1);

    state_e            state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              illegal_q, illegal_d;
    logic              bus_err_q, bus_err_d;

    logic [6:0] opcode;
    logic [3:0] dec_alu_ctrl;
    logic       dec_legal;
    logic       req_state;
    logic       timeout;
    logic       unused_instr_bits;

    assign opcode            = instr[6:0];
    assign unused_instr_bits = ^{instr[24:15], instr[11:7]};

    alu_ctrl_dec u_alu_ctrl_dec (
        .opcode   (opcode),
        .funct3   (instr[14:12]),
        .funct7   (instr[31:25]),
        .alu_ctrl (dec_alu_ctrl),
        .legal    (dec_legal)
    );

    assign req_state = (state_q == ST_FETCH) || (state_q == ST_MEM_RD) ||
                       (state_q == ST_MEM_WR);
    // Last permitted waiting cycle: a late mem_ready here still completes.
    assign timeout   = req_state && !mem_ready &&
                       (wait_q == WAIT_W'(MAX_WAIT - 1));

    always_comb begin
        state_d   = state_q;
        illegal_d = illegal_q;
        bus_err_d = bus_err_q;
        wait_d    = (req_state && !mem_ready) ? wait_q + WAIT_W'(1) : '0;
        case (state_q)
            ST_FETCH: begin
                if (mem_ready) begin
                    state_d = ST_DECODE;
                end else if (timeout) begin
                    state_d   = ST_HALT;
                    bus_err_d = 1'b1;
                end
            end
            ST_DECODE: begin
                if (!dec_legal) begin
                    state_d   = ST_HALT;
                    illegal_d = 1'b1;
                end else begin
                    case (opcode)
                        OP_LOAD, OP_STORE: state_d = ST_MEM_ADDR;
                        OP_BRANCH:         state_d = ST_BRANCH;
                        default:           state_d = ST_EXEC;
                    endcase
                end
            end
            ST_MEM_ADDR: state_d = (opcode == OP_LOAD) ? ST_MEM_RD : ST_MEM_WR;
            ST_MEM_RD: begin
                if (mem_ready) begin
                    state_d = ST_MEM_WB;
                end else if (timeout) begin
                    state_d   = ST_HALT;
                    bus_err_d = 1'b1;
                end
            end
            ST_MEM_WB: state_d = ST_FETCH;
            ST_MEM_WR: begin
                if (mem_ready) begin
                    state_d = ST_FETCH;
                end else if (timeout) begin
                    state_d   = ST_HALT;
                    bus_err_d = 1'b1;
                end
            end
            ST_EXEC:   state_d = ST_ALU_WB;
            ST_ALU_WB: state_d = ST_FETCH;
            ST_BRANCH: state_d = ST_FETCH;
            ST_HALT:   state_d = ST_HALT;
            default:   state_d = ST_HALT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_FETCH;
            wait_q    <= '0;
            illegal_q <= 1'b0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            illegal_q <= illegal_d;
            bus_err_q <= bus_err_d;
        end
    end

    // Outputs are forced idle while rst_n is low so an in-flight request
    // drops the moment reset asserts, even though the reset state is FETCH.
    always_comb begin
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        iord       = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = SRCB_RS2;
        alu_ctrl   = ALU_ADD;
        reg_write  = 1'b0;
        mem_to_reg = 1'b0;
        if (rst_n) begin
            case (state_q)
                ST_FETCH: begin
                    mem_req   = 1'b1;
                    alu_src_b = SRCB_FOUR;
                    ir_write  = mem_ready;
                    pc_write  = mem_ready;
                end
                ST_DECODE: alu_src_b = SRCB_IMM;
                ST_MEM_ADDR: begin
                    alu_src_a = 1'b1;
                    alu_src_b = SRCB_IMM;
                end
                ST_MEM_RD: begin
                    mem_req = 1'b1;
                    iord    = 1'b1;
                end
                ST_MEM_WB: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 1'b1;
                end
                ST_MEM_WR: begin
                    mem_req = 1'b1;
                    iord    = 1'b1;
                    mem_we  = 1'b1;
                end
                ST_EXEC: begin
                    alu_src_a = 1'b1;
                    alu_src_b = (opcode == OP_IMM) ? SRCB_IMM : SRCB_RS2;
                    alu_ctrl  = dec_alu_ctrl;
                end
                ST_ALU_WB: reg_write = 1'b1;
                ST_BRANCH: begin
                    alu_src_a = 1'b1;
                    alu_ctrl  = ALU_SUB;
                    pc_write  = zero;
                    pc_src    = 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign illegal = illegal_q;
    assign bus_err = bus_err_q;
    assign state   = state_q;

`ifdef MC_PERF_CNT_EN
    logic [CNT_W-1:0] cycle_q, cycle_d;
    logic [CNT_W-1:0] instret_q, instret_d;
    logic             retire;

    assign retire = (state_q == ST_MEM_WB) || (state_q == ST_ALU_WB) ||
                    (state_q == ST_BRANCH) ||
                    ((state_q == ST_MEM_WR) && mem_ready);

    always_comb begin
        cycle_d   = (state_q != ST_HALT) ? cycle_q + CNT_W'(1) : cycle_q;
        instret_d = retire ? instret_q + CNT_W'(1) : instret_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cycle_q   <= '0;
            instret_q <= '0;
        end else begin
            cycle_q   <= cycle_d;
            instret_q <= instret_d;
        end
    end

    assign cycle_cnt   = cycle_q;
    assign instret_cnt = instret_q;
`else
    // Performance counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed testbench for multicycle_ctrl. Inputs change 1 time unit after the
// rising edge; outputs are sampled 3 time units after the rising edge.
module tb_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] instr;
    logic        zero;
    logic        mem_ready;
    logic        mem_req, mem_we, iord, ir_write, pc_write, pc_src, alu_src_a;
    logic [1:0]  alu_src_b;
    logic [3:0]  alu_ctrl;
    logic        reg_write, mem_to_reg, illegal, bus_err;
    logic [3:0]  state;
`ifdef MC_PERF_CNT_EN
    logic [3:0]  cycle_cnt, instret_cnt;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    multicycle_ctrl #(
        .MAX_WAIT(16)
`ifdef MC_PERF_CNT_EN
        , .CNT_W(4)
`endif
    ) dut (
        .clk(clk), .rst_n(rst_n), .instr(instr), .zero(zero), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_we(mem_we), .iord(iord), .ir_write(ir_write),
        .pc_write(pc_write), .pc_src(pc_src), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_ctrl(alu_ctrl), .reg_write(reg_write),
        .mem_to_reg(mem_to_reg), .illegal(illegal), .bus_err(bus_err),
`ifdef MC_PERF_CNT_EN
        .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt),
`endif
        .state(state)
    );

    // {mem_req, mem_we, iord, ir_write, pc_write, pc_src, alu_src_a, alu_src_b, alu_ctrl, reg_write, mem_to_reg}
    wire [14:0] ctl = {mem_req, mem_we, iord, ir_write, pc_write, pc_src, alu_src_a,
                       alu_src_b, alu_ctrl, reg_write, mem_to_reg};

    localparam logic [3:0] S_FETCH = 4'd0, S_DECODE = 4'd1, S_MADDR = 4'd2, S_MRD = 4'd3,
                           S_MWB = 4'd4, S_MWR = 4'd5, S_EXEC = 4'd6, S_AWB = 4'd7,
                           S_BR = 4'd8, S_HALT = 4'd9;

    localparam logic [14:0] C_IDLE  = {7'b0000000, 2'b00, 4'b0010, 2'b00};
    localparam logic [14:0] C_FWAIT = {7'b1000000, 2'b01, 4'b0010, 2'b00};
    localparam logic [14:0] C_FACK  = {7'b1001100, 2'b01, 4'b0010, 2'b00};
    localparam logic [14:0] C_DEC   = {7'b0000000, 2'b10, 4'b0010, 2'b00};
    localparam logic [14:0] C_MADDR = {7'b0000001, 2'b10, 4'b0010, 2'b00};
    localparam logic [14:0] C_MRD   = {7'b1010000, 2'b00, 4'b0010, 2'b00};
    localparam logic [14:0] C_MWB   = {7'b0000000, 2'b00, 4'b0010, 2'b11};
    localparam logic [14:0] C_MWR   = {7'b1110000, 2'b00, 4'b0010, 2'b00};
    localparam logic [14:0] C_AWB   = {7'b0000000, 2'b00, 4'b0010, 2'b10};
    localparam logic [14:0] C_BR1   = {7'b0000111, 2'b00, 4'b0110, 2'b00};
    localparam logic [14:0] C_BR0   = {7'b0000011, 2'b00, 4'b0110, 2'b00};

    localparam logic [31:0] I_ADD  = 32'h002081B3;
    localparam logic [31:0] I_SUB  = 32'h402081B3;
    localparam logic [31:0] I_AND  = 32'h0020F1B3;
    localparam logic [31:0] I_OR   = 32'h0020E1B3;
    localparam logic [31:0] I_ADDI = 32'h00508193;
    localparam logic [31:0] I_BEQ  = 32'h00208463;
    localparam logic [31:0] I_LD   = 32'h0000B183;
    localparam logic [31:0] I_SD   = 32'h00113023;
    localparam logic [31:0] I_BAD  = 32'h0000007F;
    localparam logic [31:0] I_RBAD = 32'h002091B3;

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; instr = 32'h0; zero = 1'b0; mem_ready = 1'b1;
        #3;
        checks++;
        if (state !== S_FETCH || ctl !== C_IDLE || illegal !== 1'b0 || bus_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: state=%0d ctl=%h ill=%b berr=%b required state=%0d ctl=%h ill=0 berr=0",
                     state, ctl, illegal, bus_err, S_FETCH, C_IDLE);
        end
        @(posedge clk); @(posedge clk); #1;
        checks++;
        if (ctl !== C_IDLE) begin
            errors++;
            $display("FAIL reset_hold: ctl=%h required %h", ctl, C_IDLE);
        end
        rst_n = 1'b1; mem_ready = 1'b0;
        #2;
        checks++;
        if (state !== S_FETCH || ctl !== C_FWAIT) begin
            errors++;
            $display("FAIL reset_release: state=%0d ctl=%h required state=%0d ctl=%h",
                     state, ctl, S_FETCH, C_FWAIT);
        end
        next_cycle();
    endtask

    task automatic test_alu_ops();
        logic [31:0] ins [5];
        logic [3:0]  alu [5];
        logic [1:0]  srb [5];
        logic [3:0]  es  [4];
        logic [14:0] ec  [4];
        ins = '{I_ADD, I_SUB, I_AND, I_OR, I_ADDI};
        alu = '{4'b0010, 4'b0110, 4'b0000, 4'b0001, 4'b0010};
        srb = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b10};
        es  = '{S_FETCH, S_DECODE, S_EXEC, S_AWB};
        mem_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            instr = ins[k];
            ec = '{C_FACK, C_DEC, {7'b0000001, srb[k], alu[k], 2'b00}, C_AWB};
            for (int c = 0; c < 4; c++) begin
                #2;
                checks++;
                if (state !== es[c] || ctl !== ec[c]) begin
                    errors++;
                    $display("FAIL alu_op%0d_cyc%0d: state=%0d ctl=%h required state=%0d ctl=%h",
                             k, c, state, ctl, es[c], ec[c]);
                end
                next_cycle();
            end
        end
    endtask

    task automatic test_branch();
        instr = I_BEQ; mem_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            logic z;
            logic [3:0]  es [3];
            logic [14:0] ec [3];
            z  = (k == 0);
            es = '{S_FETCH, S_DECODE, S_BR};
            ec = '{C_FACK, C_DEC, z ? C_BR1 : C_BR0};
            for (int c = 0; c < 3; c++) begin
                zero = (c == 2) ? z : ~z;
                #2;
                checks++;
                if (state !== es[c] || ctl !== ec[c]) begin
                    errors++;
                    $display("FAIL branch_z%0b_cyc%0d: state=%0d ctl=%h required state=%0d ctl=%h",
                             z, c, state, ctl, es[c], ec[c]);
                end
                next_cycle();
            end
        end
        zero = 1'b0;
    endtask

    task automatic test_load_wait();
        logic        rdy [8];
        logic [3:0]  es  [8];
        logic [14:0] ec  [8];
        rdy = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        es  = '{S_FETCH, S_DECODE, S_MADDR, S_MRD, S_MRD, S_MRD, S_MRD, S_MWB};
        ec  = '{C_FACK, C_DEC, C_MADDR, C_MRD, C_MRD, C_MRD, C_MRD, C_MWB};
        instr = I_LD;
        for (int c = 0; c < 8; c++) begin
            mem_ready = rdy[c];
            #2;
            checks++;
            if (state !== es[c] || ctl !== ec[c]) begin
                errors++;
                $display("FAIL load_cyc%0d: state=%0d ctl=%h required state=%0d ctl=%h",
                         c, state, ctl, es[c], ec[c]);
            end
            next_cycle();
        end
        #2;
        checks++;
        if (state !== S_FETCH) begin
            errors++;
            $display("FAIL load_return: state=%0d required %0d", state, S_FETCH);
        end
        next_cycle();
    endtask

    task automatic test_store_reset();
        logic        rdy [9];
        logic [3:0]  es  [9];
        logic [14:0] ec  [9];
        rdy = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        es  = '{S_FETCH, S_DECODE, S_MADDR, S_MWR, S_FETCH, S_DECODE, S_MADDR, S_MWR, S_MWR};
        ec  = '{C_FACK, C_DEC, C_MADDR, C_MWR, C_FACK, C_DEC, C_MADDR, C_MWR, C_MWR};
        instr = I_SD;
        for (int c = 0; c < 9; c++) begin
            mem_ready = rdy[c];
            #2;
            checks++;
            if (state !== es[c] || ctl !== ec[c]) begin
                errors++;
                $display("FAIL store_cyc%0d: state=%0d ctl=%h required state=%0d ctl=%h",
                         c, state, ctl, es[c], ec[c]);
            end
            if (c < 8) next_cycle();
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (state !== S_FETCH || ctl !== C_IDLE || illegal !== 1'b0 || bus_err !== 1'b0) begin
            errors++;
            $display("FAIL store_async_reset: state=%0d ctl=%h ill=%b berr=%b required state=%0d ctl=%h",
                     state, ctl, illegal, bus_err, S_FETCH, C_IDLE);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic test_illegal();
        logic [31:0] ins [2];
        ins = '{I_BAD, I_RBAD};
        for (int k = 0; k < 2; k++) begin
            instr = ins[k];
            mem_ready = 1'b1;
            #2;
            checks++;
            if (state !== S_FETCH || ctl !== C_FACK) begin
                errors++;
                $display("FAIL illegal%0d_fetch: state=%0d ctl=%h required state=%0d ctl=%h",
                         k, state, ctl, S_FETCH, C_FACK);
            end
            next_cycle();
            #2;
            checks++;
            if (state !== S_DECODE || illegal !== 1'b0) begin
                errors++;
                $display("FAIL illegal%0d_decode: state=%0d ill=%b required state=%0d ill=0",
                         k, state, illegal, S_DECODE);
            end
            next_cycle();
            for (int c = 0; c < 4; c++) begin
                mem_ready = c[0];
                #2;
                checks++;
                if (state !== S_HALT || ctl !== C_IDLE || illegal !== 1'b1 || bus_err !== 1'b0) begin
                    errors++;
                    $display("FAIL illegal%0d_halt%0d: state=%0d ctl=%h ill=%b berr=%b required state=%0d ctl=%h ill=1 berr=0",
                             k, c, state, ctl, illegal, bus_err, S_HALT, C_IDLE);
                end
                next_cycle();
            end
            pulse_reset();
            #2;
            checks++;
            if (illegal !== 1'b0 || state !== S_FETCH) begin
                errors++;
                $display("FAIL illegal%0d_cleared: state=%0d ill=%b required state=%0d ill=0",
                         k, state, illegal, S_FETCH);
            end
            next_cycle();
            pulse_reset();
        end
    endtask

    task automatic test_timeout();
        instr = I_ADD;
        mem_ready = 1'b0;
        for (int c = 0; c < 16; c++) begin
            #2;
            checks++;
            if (state !== S_FETCH || ctl !== C_FWAIT || bus_err !== 1'b0) begin
                errors++;
                $display("FAIL timeout_wait%0d: state=%0d ctl=%h berr=%b required state=%0d ctl=%h berr=0",
                         c, state, ctl, bus_err, S_FETCH, C_FWAIT);
            end
            next_cycle();
        end
        for (int c = 0; c < 2; c++) begin
            mem_ready = (c == 1);
            #2;
            checks++;
            if (state !== S_HALT || ctl !== C_IDLE || bus_err !== 1'b1 || illegal !== 1'b0) begin
                errors++;
                $display("FAIL timeout_halt%0d: state=%0d ctl=%h berr=%b ill=%b required state=%0d ctl=%h berr=1 ill=0",
                         c, state, ctl, bus_err, illegal, S_HALT, C_IDLE);
            end
            next_cycle();
        end
        pulse_reset();
        // ready arriving in the last permitted cycle completes the fetch
        for (int c = 0; c < 16; c++) begin
            mem_ready = (c == 15);
            next_cycle();
        end
        mem_ready = 1'b0;
        #2;
        checks++;
        if (state !== S_DECODE || bus_err !== 1'b0) begin
            errors++;
            $display("FAIL timeout_ready_wins: state=%0d berr=%b required state=%0d berr=0",
                     state, bus_err, S_DECODE);
        end
        next_cycle();
        pulse_reset();
    endtask

`ifdef MC_PERF_CNT_EN
    task automatic test_perf();
        rst_n = 1'b0;
        #2;
        checks++;
        if (cycle_cnt !== 4'd0 || instret_cnt !== 4'd0) begin
            errors++;
            $display("FAIL perf_reset: cycle=%0d instret=%0d required 0 0", cycle_cnt, instret_cnt);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        instr = I_ADD;
        mem_ready = 1'b1;
        for (int c = 0; c < 80; c++) next_cycle();
        #2;
        checks++;
        if (instret_cnt !== 4'd4 || cycle_cnt !== 4'd0 || state !== S_FETCH) begin
            errors++;
            $display("FAIL perf_wrap: cycle=%0d instret=%0d state=%0d required cycle=0 instret=4 state=%0d",
                     cycle_cnt, instret_cnt, state, S_FETCH);
        end
        instr = I_BAD;
        for (int c = 0; c < 7; c++) next_cycle();
        #2;
        checks++;
        if (cycle_cnt !== 4'd2 || instret_cnt !== 4'd4 || state !== S_HALT) begin
            errors++;
            $display("FAIL perf_halt_freeze: cycle=%0d instret=%0d state=%0d required cycle=2 instret=4 state=%0d",
                     cycle_cnt, instret_cnt, state, S_HALT);
        end
        next_cycle();
        pulse_reset();
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: time=%0t required completion", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_alu_ops();
        test_branch();
        test_load_wait();
        test_store_reset();
        test_illegal();
        test_timeout();
`ifdef MC_PERF_CNT_EN
        test_perf();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
